ir_nec_frame: RTL
=================

# ir_nec_frame

NEC frame assembler that sits directly downstream of the 50 µs pulse classifier (`us_50_cnt`) on the 50 MHz IR receive path. It takes the falling-edge strobe and the per-bit classification strobes, and detects the leader and repeat codes by measuring edge-to-edge intervals itself. It shifts in 32 data bits LSB-first, checks the complement bytes, and presents address and command with a one-cycle valid pulse. Repeat codes and malformed or timed-out frames get separate pulses.

## Interface
- `TICK_CYC`, 2500: clock cycles per 50 µs tick.
- `LEAD_MIN`/`LEAD_MAX`, 260/280: leader edge-to-edge window in ticks (nominal 270 = 13.5 ms).
- `REP_MIN`/`REP_MAX`, 215/235: repeat edge-to-edge window in ticks (nominal 225 = 11.25 ms).
- `TMO_TICKS`, 400: ticks without a falling edge that count as a timeout (20 ms).
- `CLOCK_50` input 1: 50 MHz clock. This is the only clock.
- `rst` input 1: reset, synchronous, active-high.
- `ir_neg_I` input 1: one-cycle falling-edge strobe of the IR line.
- `bit0_I` input 1: classifier strobe for a "0" bit. It arrives exactly one cycle after the `ir_neg_I` it belongs to.
- `bit1_I` input 1: classifier strobe for a "1" bit, with the same timing as `bit0_I`.
- `addr_O` output 16: decoded address. Holds its value until the next good frame.
- `cmd_O` output 8: decoded command. Holds its value until the next good frame.
- `frame_vld_O` output 1: one-cycle pulse marking a good frame.
- `repeat_O` output 1: one-cycle pulse marking a repeat code.
- `err_O` output 1: one-cycle pulse marking a bad bit, a failed complement check, or a timeout mid-frame.

## Operation
- `neg_d` is `ir_neg_I` registered once. All decisions are taken on `neg_d`, so they line up with `bit0_I`/`bit1_I`.
- **Tick generator:** prescaler counts 0..`TICK_CYC`-1 and emits `tick` at wrap. It is cleared on `neg_d`.
- **Interval counter:** 9-bit, counts ticks, saturates at 511, cleared on `neg_d`.
- **States:** IDLE, LEAD, DATA, CHECK.
- **IDLE:**
  - On `neg_d`, go to LEAD.
- **LEAD:**
  - On `neg_d` with interval in [`LEAD_MIN`,`LEAD_MAX`]: go to DATA, set `bit_cnt` = 0.
  - On `neg_d` with interval in [`REP_MIN`,`REP_MAX`]: pulse `repeat_O` if `last_ok` = 1, then stay in LEAD.
  - On `neg_d` with any other interval: stay in LEAD. The edge restarts the measurement.
  - On interval = `TMO_TICKS`: go to IDLE with no error.
- **DATA:**
  - On `neg_d` with `bit1_I` only: `shreg <= {1, shreg[31:1]}`.
  - On `neg_d` with `bit0_I` only: `shreg <= {0, shreg[31:1]}`.
  - After either shift, increment `bit_cnt` (6-bit). When the 32nd bit is shifted in, go to CHECK.
  - On `neg_d` with no strobe, or with both strobes: pulse `err_O`, clear `last_ok`, go to IDLE.
  - On interval = `TMO_TICKS`: pulse `err_O`, clear `last_ok`, go to IDLE.
- **CHECK** (lasts one cycle, then IDLE):
  - Byte layout of `shreg`: [7:0] addr, [15:8] addr_n, [23:16] cmd, [31:24] cmd_n.
  - The command check is `cmd_n == ~cmd`.
  - If the check passes: load `addr_O`/`cmd_O`, pulse `frame_vld_O`, set `last_ok`.
  - If it fails: pulse `err_O`, clear `last_ok`. `addr_O`/`cmd_O` are unchanged.
- **Simultaneous events:** when `neg_d` and timeout occur in the same cycle, `neg_d` wins.
- **Reset:** clears all state immediately, including mid-frame. Afterwards the state is IDLE, `last_ok` = 0, and all outputs are 0.

## Timing
- Take the `ir_neg_I` that ends bit 32 as cycle 0. `neg_d` is high in cycle 1, CHECK is in cycle 2, and `frame_vld_O`/`addr_O`/`cmd_O` are valid from cycle 3.
- `repeat_O` is high in cycle 2 relative to its `ir_neg_I`.
- `err_O` from a bad bit is high in cycle 2 relative to its `ir_neg_I`.
- `err_O` from a failed check is high in cycle 3.
- Every pulse output is high for exactly one cycle.
- Reset values: `addr_O` = 0, `cmd_O` = 0, and all pulse outputs = 0.

## Configuration
- Macro: `IR_EXT_ADDR_EN` (extended NEC).
- **Defined:** `addr_O` = `shreg[15:0]` and there is no address complement check. Only the command complement is checked.
- **Undefined:** requires `shreg[15:8] == ~shreg[7:0]`. `addr_O` = {8'h00, `shreg[7:0]`}.

## Structure
- **Package `ir_nec_pkg`:**
  - state enum;
  - default tick and window constants;
  - byte-lane index constants for addr, addr_n, cmd, cmd_n.
- **Sub-module `ir_tick_gen`:** prescaler with a synchronous clear, producing `tick`.
- **Top module:** holds the FSM, interval counter, shift register and output registers.

## Test plan
- **Good frame:** leader, then bits for addr 0x5A, ~0x5A, cmd 0x13, ~0x13 (LSB-first). Expect `frame_vld_O` for one cycle at cycle 3, `addr_O` = 0x005A, `cmd_O` = 0x13, and no `err_O`.
- **Repeat after a good frame:** edges 225 ticks apart give `repeat_O` = 1. The same stimulus straight after reset gives no `repeat_O`.
- **Bad complement:** cmd_n = 0xEE with cmd = 0x13. Expect `err_O` at cycle 3 and `addr_O`/`cmd_O` unchanged.
- **Missing bit strobe:** `ir_neg_I` with no `bit0_I`/`bit1_I` at bit 10. Expect `err_O` at cycle 2 and state IDLE.
- **Mid-frame timeout:** stop edges after bit 20. Expect `err_O` once, 400 ticks after the last edge.
- **Reset mid-DATA:** assert `rst` mid-frame. Expect all outputs 0. A following complete frame must decode correctly.
- **With `IR_EXT_ADDR_EN`:** address bytes 0x34, 0x12. Expect `addr_O` = 0x1234 and `frame_vld_O` = 1.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared types and constants for the NEC IR frame assembler.
package ir_nec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam int TICK_CYC_DEF  = 2500;
    localparam int LEAD_MIN_DEF  = 260;
    localparam int LEAD_MAX_DEF  = 280;
    localparam int REP_MIN_DEF   = 215;
    localparam int REP_MAX_DEF   = 235;
    localparam int TMO_TICKS_DEF = 400;

    localparam int LANE_ADDR   = 0;
    localparam int LANE_ADDR_N = 1;
    localparam int LANE_CMD    = 2;
    localparam int LANE_CMD_N  = 3;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
        return word[lane*8 +: 8];
    endfunction

    function automatic logic cmpl_ok(input logic [7:0] b, input logic [7:0] b_n);
        return (b_n == ~b);
    endfunction

endpackage

// File: rtl/ir_nec_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_CYC clocks; restartable by a synchronous clear.
module ir_tick_gen #(
    parameter int TICK_CYC = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] L_LAST = CW'(TICK_CYC - 1);

    logic [CW-1:0] r_cnt;

    // prescaler: wraps at L_LAST, restarted by each edge so ticks are edge-aligned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == L_LAST);

endmodule

// File: rtl/ir_nec_frame.sv
// NEC IR frame assembler: leader/repeat detection, 32-bit LSB-first shift, complement check.
// Macro IR_EXT_ADDR_EN selects extended NEC (16-bit address, command complement only).
module ir_nec_frame
    import ir_nec_pkg::*;
#(
    parameter int TICK_CYC  = TICK_CYC_DEF,
    parameter int LEAD_MIN  = LEAD_MIN_DEF,
    parameter int LEAD_MAX  = LEAD_MAX_DEF,
    parameter int REP_MIN   = REP_MIN_DEF,
    parameter int REP_MAX   = REP_MAX_DEF,
    parameter int TMO_TICKS = TMO_TICKS_DEF
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        ir_neg_I,
    input  logic        bit0_I,
    input  logic        bit1_I,
    output logic [15:0] addr_O,
    output logic [7:0]  cmd_O,
    output logic        frame_vld_O,
    output logic        repeat_O,
    output logic        err_O
);

    localparam logic [8:0] L_LEAD_MIN = 9'(LEAD_MIN);
    localparam logic [8:0] L_LEAD_MAX = 9'(LEAD_MAX);
    localparam logic [8:0] L_REP_MIN  = 9'(REP_MIN);
    localparam logic [8:0] L_REP_MAX  = 9'(REP_MAX);
    localparam logic [8:0] L_TMO      = 9'(TMO_TICKS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_neg_d;
    logic        w_tick;
    logic [8:0]  r_interval;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_shreg;
    logic        r_last_ok;
    logic [15:0] r_addr;
    logic [7:0]  r_cmd;
    logic        r_vld;
    logic        r_rep;
    logic        r_err;

    logic        w_in_lead;
    logic        w_in_rep;
    logic        w_tmo;
    logic        w_bit_ok;
    logic        w_last_bit;
    logic        w_cmd_ok;
    logic        w_addr_ok;
    logic        w_chk_ok;
    logic [15:0] w_addr_dec;

    logic        w_shift;
    logic        w_bit_clr;
    logic        w_rep;
    logic        w_err;
    logic        w_vld;

    ir_tick_gen #(
        .TICK_CYC (TICK_CYC)
    ) u_tick (
        .i_clk  (CLOCK_50),
        .i_rst  (rst),
        .i_clr  (r_neg_d),
        .o_tick (w_tick)
    );

    assign w_in_lead  = (r_interval >= L_LEAD_MIN) && (r_interval <= L_LEAD_MAX);
    assign w_in_rep   = (r_interval >= L_REP_MIN) && (r_interval <= L_REP_MAX);
    assign w_tmo      = (r_interval == L_TMO);
    assign w_bit_ok   = bit0_I ^ bit1_I;
    assign w_last_bit = (r_bit_cnt == 6'd31);
    assign w_cmd_ok   = cmpl_ok(lane_byte(r_shreg, LANE_CMD), lane_byte(r_shreg, LANE_CMD_N));

`ifdef IR_EXT_ADDR_EN
    assign w_addr_ok  = 1'b1;
    assign w_addr_dec = r_shreg[15:0];
`else
    assign w_addr_ok  = cmpl_ok(lane_byte(r_shreg, LANE_ADDR), lane_byte(r_shreg, LANE_ADDR_N));
    assign w_addr_dec = {8'h00, lane_byte(r_shreg, LANE_ADDR)};
`endif

    assign w_chk_ok = w_cmd_ok & w_addr_ok;

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; an edge takes priority over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_neg_d) w_state_nxt = ST_LEAD;
                else         w_state_nxt = ST_IDLE;
            end
            ST_LEAD: begin
                if (r_neg_d) w_state_nxt = w_in_lead ? ST_DATA : ST_LEAD;
                else if (w_tmo) w_state_nxt = ST_IDLE;
                else w_state_nxt = ST_LEAD;
            end
            ST_DATA: begin
                if (r_neg_d) begin
                    if (w_bit_ok) w_state_nxt = w_last_bit ? ST_CHECK : ST_DATA;
                    else          w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_CHECK: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // per-state control strobes
    always_comb begin
        w_shift   = 1'b0;
        w_bit_clr = 1'b0;
        w_rep     = 1'b0;
        w_err     = 1'b0;
        w_vld     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_shift = 1'b0;
            end
            ST_LEAD: begin
                if (r_neg_d) begin
                    w_bit_clr = w_in_lead;
                    w_rep     = w_in_rep & r_last_ok;
                end else begin
                    w_rep = 1'b0;
                end
            end
            ST_DATA: begin
                if (r_neg_d) begin
                    w_shift = w_bit_ok;
                    w_err   = ~w_bit_ok;
                end else begin
                    w_err = w_tmo;
                end
            end
            ST_CHECK: begin
                w_vld = w_chk_ok;
                w_err = ~w_chk_ok;
            end
            default: begin
                w_err = 1'b0;
            end
        endcase
    end

    // edge delay, interval measurement and bit shifting
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_neg_d    <= 1'b0;
            r_interval <= 9'd0;
            r_bit_cnt  <= 6'd0;
            r_shreg    <= 32'd0;
        end else begin
            r_neg_d <= ir_neg_I;
            if (r_neg_d) begin
                r_interval <= 9'd0;
            end else if (w_tick && (r_interval != 9'h1FF)) begin
                r_interval <= r_interval + 9'd1;
            end else begin
                r_interval <= r_interval;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= 6'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            if (w_shift) begin
                r_shreg <= {bit1_I, r_shreg[31:1]};
            end else begin
                r_shreg <= r_shreg;
            end
        end
    end

    // registered results; last_ok gates repeat reporting
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_last_ok <= 1'b0;
            r_addr    <= 16'd0;
            r_cmd     <= 8'd0;
            r_vld     <= 1'b0;
            r_rep     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_vld) begin
                r_last_ok <= 1'b1;
                r_addr    <= w_addr_dec;
                r_cmd     <= lane_byte(r_shreg, LANE_CMD);
            end else if (w_err) begin
                r_last_ok <= 1'b0;
            end else begin
                r_last_ok <= r_last_ok;
            end
            r_vld <= w_vld;
            r_rep <= w_rep;
            r_err <= w_err;
        end
    end

    assign addr_O      = r_addr;
    assign cmd_O       = r_cmd;
    assign frame_vld_O = r_vld;
    assign repeat_O    = r_rep;
    assign err_O       = r_err;

endmodule
